mmu_loader: RTL
===============

# mmu_loader

Sequencer that bulk-loads the MMU translation table from a memory-resident image. On `start` it reads 4*NMMU entry words from memory and writes each one into the MMU through the MMU's register port. For every entry it issues a select write (bit0=0, index fields) followed by a load write (bit0=1). It sits beside the MMU on its register port and shares the port with CPU register writes through the `busy` interlock.

## Interface
Parameters:
- RV, 16, register/data width
- PA, RV, physical address width
- VA, RV, virtual address width
- NMMU, 8, pages per table (4*NMMU entries total)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin load; sampled only in IDLE
- base  in  PA-RV/16  word address of entry 0
- busy  out  1  load in progress; CPU must not drive MMU register port
- done  out  1  one-cycle pulse at completion
- mem_req  out  1  memory read request
- mem_addr  out  PA-RV/16  read word address
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  RV  entry word
- mmu_fault  in  1  MMU fault capture this cycle; the MMU drops register writes
- mmu_reg_read  in  RV  MMU register read value
- mmu_reg_write  out  1  MMU register write strobe
- mmu_reg_data  out  RV  MMU register write data

## Operation
- Local constants: U = VA-$clog2(NMMU); entry index idx is $clog2(NMMU)+2 bits, with idx = {ins, data, page}.
- States: IDLE, FETCH, SELECT, LOAD, RESTORE, DONE.
- IDLE:
  - On `start`, set idx=0 and mem_addr=base.
  - Capture mmu_reg_read into save_reg.
  - Go to FETCH.
- FETCH:
  - mem_req=1 and mem_addr held stable until mem_ack.
  - On mem_ack, latch mem_rdata into entry_reg and go to SELECT.
- SELECT:
  - mmu_reg_write=1.
  - mmu_reg_data has [VA-1:U]=page, bit4=ins, bit3=data, and all other bits 0.
  - Go to LOAD.
- LOAD:
  - mmu_reg_write=1 and mmu_reg_data = entry_reg with bit0 forced to 1.
  - If idx is the last entry (4*NMMU-1), go to RESTORE.
  - Otherwise increment idx and mem_addr and go to FETCH.
- RESTORE:
  - mmu_reg_write=1 and mmu_reg_data = save_reg with bit0 forced to 0.
  - Go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- mmu_fault in any write state (SELECT, LOAD, RESTORE): the MMU discards that write, so the loader holds its state and data and repeats the write next cycle.
- mmu_fault during SELECT→LOAD ordering: if a fault lands between SELECT and LOAD it overwrites the index, so on a fault in LOAD the loader returns to SELECT.
- `start` while busy is ignored.
- mem_ack outside FETCH is ignored.
- mem_addr wraps modulo 2^(PA-RV/16).

## Timing
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, mmu_reg_write=0, mmu_reg_data=0.
- All outputs are registered from state except mmu_reg_data, which is muxed from registers.
- Reset mid-load returns to IDLE next edge with all outputs at reset values. Entries already written stay in the MMU.
- busy is high from the cycle after start is accepted through DONE inclusive.
- Per entry (ack in first FETCH cycle, no faults): 3 cycles.
- Full load: 3*4*NMMU + RESTORE 1 + DONE 1 cycles (98 cycles for NMMU=8).

## Configuration
- MMU_LOADER_RESTORE_EN:
  - Defined: save_reg capture and the RESTORE state exist. After the load, the MMU fault/index register equals its value at start.
  - Undefined: LOAD of the last entry goes straight to DONE, and the fault/index register is left pointing at entry 4*NMMU-1. Full load takes 3*4*NMMU+1 cycles.

## Structure
- Shared package `mmu_pkg`:
  - state enum `mmu_loader_state_t`
  - control bit positions (VLD=1, WR=2, DATA=3, INS=4, SEL=0)
  - function computing U from VA and NMMU
- No sub-module. A single FSM plus the idx and address counters.

## Test plan
- NMMU=8, base=0x100, ack same cycle, memory[i]=(i<<13)|0x6:
  - 32 SELECT/LOAD pairs with select data for idx=0x1F = 0xE018.
  - The mmu model holds all 32 mappings.
  - done pulses at cycle 98.
- Random 0–3 cycle ack delay: mem_addr stable while mem_req is high, mem_req never overlaps mmu_reg_write, and the final table matches.
- mmu_fault asserted during the LOAD of idx=5: state returns to SELECT, the entry is rewritten, and the mmu model entry 5 is correct.
- save_reg=0xA012 at start (MMU_LOADER_RESTORE_EN defined): the last write is 0xA012 and the fault register reads 0xA012 after done.
- reset asserted at idx=10: next cycle all outputs are 0 and busy=0. A new start reloads from idx 0.
- start pulsed while busy: ignored, so exactly one done pulse occurs.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared MMU definitions: loader FSM states, register-port control bit
// positions and the page-field position helper.
package mmu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SELECT,
    LOAD,
    RESTORE,
    DONE
  } mmu_loader_state_t;

  // Control bit positions in an MMU register-port write word
  localparam int unsigned SEL  = 0;
  localparam int unsigned VLD  = 1;
  localparam int unsigned WR   = 2;
  localparam int unsigned DATA = 3;
  localparam int unsigned INS  = 4;

  // Low bit of the page field in a virtual address
  function automatic int unsigned calc_u(input int unsigned va, input int unsigned nmmu);
    return va - $clog2(nmmu);
  endfunction

endpackage

// File: rtl/mmu_loader_if.sv
// Loader bus bundle: memory read port plus MMU register port.
//   master (loader): drives mem_req/mem_addr and mmu_reg_write/mmu_reg_data
//   slave  (memory + MMU): drives mem_ack/mem_rdata, mmu_fault/mmu_reg_read
interface mmu_loader_if #(
  parameter int unsigned RV = 16,
  parameter int unsigned PA = RV
);
  localparam int unsigned AW = PA - RV / 16;

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [RV-1:0] mem_rdata;
  logic          mmu_fault;
  logic [RV-1:0] mmu_reg_read;
  logic          mmu_reg_write;
  logic [RV-1:0] mmu_reg_data;

  modport master (
    output mem_req, mem_addr, mmu_reg_write, mmu_reg_data,
    input  mem_ack, mem_rdata, mmu_fault, mmu_reg_read
  );

  modport slave (
    input  mem_req, mem_addr, mmu_reg_write, mmu_reg_data,
    output mem_ack, mem_rdata, mmu_fault, mmu_reg_read
  );
endinterface

// File: rtl/mmu_loader.sv
// Bulk loader for the MMU translation table. On start it fetches 4*NMMU
// entry words from memory starting at base and writes each into the MMU as
// a select write (index fields, bit0=0) followed by a load write (bit0=1).
// Optional feature macro MMU_LOADER_RESTORE_EN: save the MMU fault/index
// register at start and write it back after the last entry.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   start       begin load (sampled in IDLE only)
//   base        word address of entry 0
//   busy        load in progress; CPU must keep off the MMU register port
//   done        one-cycle completion pulse
//   bus         mmu_loader_if.master: memory read + MMU register port
module mmu_loader
  import mmu_pkg::*;
#(
  parameter int unsigned RV   = 16,
  parameter int unsigned PA   = RV,
  parameter int unsigned VA   = RV,
  parameter int unsigned NMMU = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PA-RV/16-1:0]  base,
  output logic                 busy,
  output logic                 done,
  mmu_loader_if.master         bus
);

  localparam int unsigned AW = PA - RV / 16;
  localparam int unsigned PW = $clog2(NMMU);
  localparam int unsigned IW = PW + 2;
  localparam int unsigned U  = calc_u(VA, NMMU);
  localparam logic [IW-1:0] LAST = IW'(4 * NMMU - 1);

  mmu_loader_state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [RV-1:0] entry_reg, entry_n;
  logic [RV-1:0] sel_data;
  logic          mem_req_q, reg_write_q;

`ifdef MMU_LOADER_RESTORE_EN
  logic [RV-1:0] save_reg, save_n;
`else
  logic unused_reg_read;
  assign unused_reg_read = ^bus.mmu_reg_read;
`endif

  // State and datapath registers; outputs registered from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      addr_q      <= '0;
      entry_reg   <= '0;
`ifdef MMU_LOADER_RESTORE_EN
      save_reg    <= '0;
`endif
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_req_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      addr_q      <= addr_n;
      entry_reg   <= entry_n;
`ifdef MMU_LOADER_RESTORE_EN
      save_reg    <= save_n;
`endif
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      mem_req_q   <= (state_n == FETCH);
      reg_write_q <= (state_n == SELECT) || (state_n == LOAD) || (state_n == RESTORE);
    end
  end

  // Next-state logic; a faulted MMU write is simply repeated
  always_comb begin
    state_n = state;
    idx_n   = idx;
    addr_n  = addr_q;
    entry_n = entry_reg;
`ifdef MMU_LOADER_RESTORE_EN
    save_n  = save_reg;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          idx_n   = '0;
          addr_n  = base;
`ifdef MMU_LOADER_RESTORE_EN
          save_n  = bus.mmu_reg_read;
`endif
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (bus.mem_ack) begin
          entry_n = bus.mem_rdata;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (!bus.mmu_fault) state_n = LOAD;
      end
      LOAD: begin
        // A fault here clobbers the MMU index, so the select must be redone
        if (bus.mmu_fault) begin
          state_n = SELECT;
        end else if (idx == LAST) begin
`ifdef MMU_LOADER_RESTORE_EN
          state_n = RESTORE;
`else
          state_n = DONE;
`endif
        end else begin
          idx_n   = idx + IW'(1);
          addr_n  = addr_q + AW'(1);
          state_n = FETCH;
        end
      end
`ifdef MMU_LOADER_RESTORE_EN
      RESTORE: begin
        if (!bus.mmu_fault) state_n = DONE;
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Select word: page in the VA page field, ins/data in their control bits
  always_comb begin
    sel_data          = '0;
    sel_data[VA-1:U]  = idx[PW-1:0];
    sel_data[INS]     = idx[PW+1];
    sel_data[DATA]    = idx[PW];
  end

  // Register-port write data muxed from registered state
  always_comb begin
    bus.mmu_reg_data = '0;
    case (state)
      SELECT:  bus.mmu_reg_data = sel_data;
      LOAD:    bus.mmu_reg_data = entry_reg | RV'(1);
`ifdef MMU_LOADER_RESTORE_EN
      RESTORE: bus.mmu_reg_data = save_reg & ~RV'(1);
`endif
      default: bus.mmu_reg_data = '0;
    endcase
  end

  assign bus.mem_req       = mem_req_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mmu_reg_write = reg_write_q;

endmodule
